// File: rtl/fast9_pkg.sv
// Shared sizing defaults and FSM state encoding for the FAST-9 corner collector.
package fast9_pkg;

    localparam int ADDR_W     = 15;
    localparam int SLOT_W     = 4;
    localparam int NUM_SLOTS  = 16;
    localparam int IMG_PIXELS = 32768;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        READOUT
    } state_e;

endpackage

// File: rtl/fast9_slot_alloc.sv
// Hands out position slots to accepted corners in order and issues the slot write strobe.
module fast9_slot_alloc
    import fast9_pkg::*;
#(
    parameter int SLOT_W    = fast9_pkg::SLOT_W,
    parameter int NUM_SLOTS = fast9_pkg::NUM_SLOTS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              match_accept,
    output logic [SLOT_W-1:0] slot,
    output logic              wr,
    output logic              full,
    output logic [SLOT_W:0]   count,
    output logic              overflow
);

    localparam logic [SLOT_W:0] FULL_CNT = (SLOT_W+1)'(NUM_SLOTS);

    logic [SLOT_W:0]   cnt_q,  cnt_d;
    logic              ovf_q,  ovf_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              wr_q,   wr_d;

    assign full = (cnt_q == FULL_CNT);

    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        slot_d = slot_q;
        wr_d   = 1'b0;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (match_accept) begin
            // A match with every slot taken is dropped but remembered.
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                slot_d = cnt_q[SLOT_W-1:0];
                wr_d   = 1'b1;
                cnt_d  = cnt_q + (SLOT_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            slot_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            slot_q <= slot_d;
            wr_q   <= wr_d;
        end
    end

    assign slot     = slot_q;
    assign wr       = wr_q;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/fast9_corner_collector.sv
// Scans the frame raster, forwards FAST-9 corners to the slot bank and
// presents the position bundle at end of frame until the consumer acknowledges.
module fast9_corner_collector
    import fast9_pkg::*;
#(
    parameter int ADDR_W     = fast9_pkg::ADDR_W,
    parameter int SLOT_W     = fast9_pkg::SLOT_W,
    parameter int NUM_SLOTS  = fast9_pkg::NUM_SLOTS,
    parameter int IMG_PIXELS = fast9_pkg::IMG_PIXELS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pix_valid,
    input  logic              mat_point,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] ref_addr,
    output logic [SLOT_W-1:0] pos_addr,
    output logic              pos_wr,
    output logic              pos_readen,
    output logic [SLOT_W:0]   corner_cnt,
    output logic              overflow,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_PIXELS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] scan_q,  scan_d;
    logic [ADDR_W-1:0] ref_q,   ref_d;
    logic              rden_q,  rden_d;
    logic              clear;
    logic              accept;
    logic              full;

    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        rden_d  = rden_q;
        clear   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    scan_d  = '0;
                    clear   = 1'b1;
                end
            end
            SCAN: begin
                if (pix_valid) begin
                    accept = mat_point;
                    scan_d = scan_q + ADDR_W'(1);
                    // Last-pixel compare fires before the counter can wrap.
                    if (scan_q == LAST_PIX) begin
                        state_d = READOUT;
                        rden_d  = 1'b1;
                    end
                end
            end
            READOUT: begin
                if (rd_ack) begin
                    state_d = IDLE;
                    rden_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        ref_d = (accept && !full) ? scan_q : ref_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            scan_q  <= '0;
            ref_q   <= '0;
            rden_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            ref_q   <= ref_d;
            rden_q  <= rden_d;
        end
    end

    fast9_slot_alloc #(
        .SLOT_W    (SLOT_W),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slot_alloc (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .match_accept (accept),
        .slot         (pos_addr),
        .wr           (pos_wr),
        .full         (full),
        .count        (corner_cnt),
        .overflow     (overflow)
    );

    assign ref_addr   = ref_q;
    assign pos_readen = rden_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fast9_corner_collector.sv
// Randomised scoreboard bench for fast9_corner_collector on a 64-pixel frame.
module tb_fast9_corner_collector;

    localparam int ADDR_W = 6;
    localparam int SLOT_W = 4;
    localparam int NSLOT  = 16;
    localparam int NPIX   = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, pix_valid, mat_point, rd_ack;
    logic [ADDR_W-1:0] ref_addr;
    logic [SLOT_W-1:0] pos_addr;
    logic              pos_wr, pos_readen, overflow, busy;
    logic [SLOT_W:0]   corner_cnt;

    typedef struct { int raddr; int slot; int cyc; } wr_t;
    typedef struct { int cnt; int ovf; int cyc; } rd_t;

    wr_t wq[$];
    rd_t rq[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    bit  prev_rden = 1'b0;
    wr_t we;
    rd_t re;

    fast9_corner_collector #(
        .ADDR_W(ADDR_W), .SLOT_W(SLOT_W), .NUM_SLOTS(NSLOT), .IMG_PIXELS(NPIX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
        .mat_point(mat_point), .rd_ack(rd_ack), .ref_addr(ref_addr),
        .pos_addr(pos_addr), .pos_wr(pos_wr), .pos_readen(pos_readen),
        .corner_cnt(corner_cnt), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ref_addr"},   int'(ref_addr),   0);
        chk({tag, "_pos_addr"},   int'(pos_addr),   0);
        chk({tag, "_pos_wr"},     int'(pos_wr),     0);
        chk({tag, "_pos_readen"}, int'(pos_readen), 0);
        chk({tag, "_corner_cnt"}, int'(corner_cnt), 0);
        chk({tag, "_overflow"},   int'(overflow),   0);
        chk({tag, "_busy"},       int'(busy),       0);
    endtask

    // Monitor: every write strobe and every rising pos_readen consumes one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pos_wr) begin
                if (wq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL wr_unexpected: ref_addr=%0d pos_addr=%0d, no write expected", ref_addr, pos_addr);
                end else begin
                    we = wq.pop_front();
                    chk("wr_ref_addr", int'(ref_addr), we.raddr);
                    chk("wr_pos_addr", int'(pos_addr), we.slot);
                    chk("wr_cycle",    cyc,            we.cyc);
                end
            end
            if (pos_readen && !prev_rden) begin
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rden_unexpected: pos_readen rose with no frame end expected");
                end else begin
                    re = rq.pop_front();
                    chk("ro_corner_cnt", int'(corner_cnt), re.cnt);
                    chk("ro_overflow",   int'(overflow),   re.ovf);
                    chk("ro_cycle",      cyc,              re.cyc);
                end
            end
        end
        prev_rden = pos_readen;
    end

    // vmode: 0 = pix_valid always high, 1 = toggling, 2 = random (with noise on start/rd_ack).
    task automatic run_frame(input logic [63:0] mmap, input int vmode, input int hold);
        int p, n, ovf, toggle;
        bit v, m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_cnt_clr", int'(corner_cnt), 0);
        chk("start_ovf_clr", int'(overflow),   0);
        chk("start_busy",    int'(busy),       1);
        p = 0; n = 0; ovf = 0; toggle = 0;
        while (p < NPIX) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (toggle == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            toggle ^= 1;
            m = v ? mmap[p] : 1'($urandom_range(0, 1));
            pix_valid = v;
            mat_point = m;
            if (vmode == 2) begin
                start  = 1'($urandom_range(0, 1));
                rd_ack = 1'($urandom_range(0, 1));
            end
            if (v) begin
                if (m) begin
                    if (n < NSLOT) begin
                        wq.push_back('{p, n, cyc + 1});
                        n++;
                    end else begin
                        ovf = 1;
                    end
                end
                if (p == NPIX - 1) rq.push_back('{n, ovf, cyc + 1});
                p++;
            end
            @(posedge clk); #1;
            chk("scan_corner_cnt", int'(corner_cnt), n);
            chk("scan_overflow",   int'(overflow),   ovf);
        end
        pix_valid = 1'b0; mat_point = 1'b0; start = 1'b0; rd_ack = 1'b0;
        chk("ro_busy", int'(busy), 1);
        repeat (hold) begin
            chk("ro_readen_hold", int'(pos_readen), 1);
            @(posedge clk); #1;
        end
        chk("ro_readen_pre_ack", int'(pos_readen), 1);
        rd_ack = 1'b1;
        @(posedge clk); #1;
        rd_ack = 1'b0;
        chk("ack_readen_drop", int'(pos_readen), 0);
        chk("ack_busy_idle",   int'(busy),       0);
        chk("ack_cnt_hold",    int'(corner_cnt), n);
        chk("ack_ovf_hold",    int'(overflow),   ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mm;
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; mat_point = 1'b0; rd_ack = 1'b0;
        #3;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rd_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_zero("idle");
        end
        rd_ack = 1'b0;

        mm = '0; mm[3] = 1'b1; mm[10] = 1'b1; mm[63] = 1'b1;
        run_frame(mm, 0, 2);
        run_frame({64{1'b1}}, 0, 10);
        mm = '0; mm[5] = 1'b1;
        run_frame(mm, 1, 1);
        run_frame('0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            mm = {$urandom, $urandom} & {$urandom, $urandom};
            run_frame(mm, 2, int'($urandom_range(0, 3)));
        end
        run_frame({$urandom, $urandom} | {$urandom, $urandom}, 2, 1);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int p = 0; p < 20; p++) begin
            pix_valid = 1'b1;
            mat_point = (p == 4 || p == 9);
            if (mat_point) wq.push_back('{p, (p == 4) ? 0 : 1, cyc + 1});
            @(posedge clk); #1;
        end
        chk("pre_reset_cnt", int'(corner_cnt), 2);
        chk("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async");
        pix_valid = 1'b0; mat_point = 1'b0;
        @(posedge clk); #1;
        check_zero("held_reset");
        rst_n = 1'b1;
        chk("post_reset_wq_empty", wq.size(), 0);
        run_frame(64'h7, 0, 0);

        repeat (3) @(posedge clk); #1;
        chk("final_wq_empty", wq.size(), 0);
        chk("final_rq_empty", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
